// File: rtl/fsk_tone_generator_pkg.sv
// Shared definitions for the FSK tone generator.
// Holds the state encoding, the counter width and the half-period tick
// calculation used to size both tone dividers at elaboration.
package fsk_tone_generator_pkg;

    localparam int unsigned CNT_W = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_TONE = 1'b1;

    // Clock cycles per half period of a square wave at freq_hz.
    function automatic int unsigned calc_half_ticks(input int unsigned clock_hz,
                                                    input int unsigned freq_hz);
        return clock_hz / (2 * freq_hz);
    endfunction

endpackage

// File: rtl/fsk_tone_if.sv
// Byte-in / tone-out bus of the FSK tone generator.
//   enable      : advance all counters when high, freeze when low
//   data_in     : byte to transmit, LSB first
//   data_valid  : data_in is valid
//   data_ready  : generator accepts a byte this cycle
//   sample_out  : FSK square-wave output
//   busy        : a byte is being transmitted
//   tone_sel    : data bit currently being sent
//   bytes_sent  : fully transmitted bytes since reset
interface fsk_tone_if;
    import fsk_tone_generator_pkg::*;

    logic             enable;
    logic [7:0]       data_in;
    logic             data_valid;
    logic             data_ready;
    logic             sample_out;
    logic             busy;
    logic             tone_sel;
    logic [CNT_W-1:0] bytes_sent;

    modport master (
        output enable, data_in, data_valid,
        input  data_ready, sample_out, busy, tone_sel, bytes_sent
    );

    modport slave (
        input  enable, data_in, data_valid,
        output data_ready, sample_out, busy, tone_sel, bytes_sent
    );

endinterface

// File: rtl/fsk_tone_generator_tone_divider.sv
// Half-period counter driving the square-wave output.
//   clk, rst_n     : clock, async active-low reset
//   enable_i       : advance the counter this cycle
//   restart_i      : bit boundary, counter returns to 0 (level is kept)
//   half_ticks_i   : half period in cycles for the current tone
//   sample_o       : square-wave level
module tone_divider
    import fsk_tone_generator_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] half_ticks_i,
    output logic             sample_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample_q, sample_d;
    logic             half_done;

    assign half_done = (cnt_q == half_ticks_i - CNT_W'(1));

    // A toggle due on the boundary edge still happens; only the count restarts.
    always_comb begin
        cnt_d    = cnt_q;
        sample_d = sample_q;
        if (enable_i) begin
            if (half_done) begin
                sample_d = ~sample_q;
            end
            if (half_done || restart_i) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sample_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/fsk_tone_generator.sv
// Binary FSK transmitter: sends each accepted byte LSB first, one bit per
// BIT_TICKS enabled cycles, as a square wave at FREQUENCY_1 (bit 0) or
// FREQUENCY_2 (bit 1).
//   clock : system clock, rising edge
//   clear : async active-low reset
//   bus   : fsk_tone_if slave (handshake, status and tone output)
module fsk_tone_generator
    import fsk_tone_generator_pkg::*;
#(
    parameter int unsigned FREQUENCY_1 = 9000,
    parameter int unsigned FREQUENCY_2 = 11000,
    parameter int unsigned CLOCK       = 50000000,
    parameter int unsigned BIT_TICKS   = 50000
) (
    input  logic    clock,
    input  logic    clear,
    fsk_tone_if.slave bus
);

    localparam int unsigned HALF1 = calc_half_ticks(CLOCK, FREQUENCY_1);
    localparam int unsigned HALF2 = calc_half_ticks(CLOCK, FREQUENCY_2);

    // Reject parameter sets that cannot produce two distinct, whole tones per bit.
    if (FREQUENCY_2 <= FREQUENCY_1 || HALF2 < 1 || BIT_TICKS < 2 * HALF1) begin : g_bad_params
        $error("fsk_tone_generator: invalid FREQUENCY_1/FREQUENCY_2/CLOCK/BIT_TICKS");
    end

    logic [0:0]       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] bytes_q, bytes_d;
    logic             bit_end;
    logic             sample;
    logic [CNT_W-1:0] half_sel;

    assign bit_end  = (state_q == ST_TONE) && bus.enable
                      && (bit_cnt_q == CNT_W'(BIT_TICKS - 1));
    assign half_sel = shift_q[0] ? CNT_W'(HALF2) : CNT_W'(HALF1);

    // Next-state logic: accept in IDLE, count bit duration and shift in TONE.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        bytes_d   = bytes_q;
        if (bus.enable) begin
            if (state_q == ST_IDLE) begin
                if (bus.data_valid) begin
                    shift_d   = bus.data_in;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = ST_TONE;
                end
            end else if (bit_end) begin
                bit_cnt_d = '0;
                shift_d   = {1'b0, shift_q[7:1]};
                if (bit_idx_q == CNT_W'(7)) begin
                    bit_idx_d = '0;
                    bytes_d   = bytes_q + CNT_W'(1);
                    state_d   = ST_IDLE;
                end else begin
                    bit_idx_d = bit_idx_q + CNT_W'(1);
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            bytes_q   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            bytes_q   <= bytes_d;
        end
    end

    tone_divider u_tone_divider (
        .clk          (clock),
        .rst_n        (clear),
        .enable_i     (bus.enable && (state_q == ST_TONE)),
        .restart_i    (bit_end),
        .half_ticks_i (half_sel),
        .sample_o     (sample)
    );

    // Shift register empties to zero by the end of a byte, so tone_sel reads 0 in IDLE.
    assign bus.data_ready = (state_q == ST_IDLE) && clear;
    assign bus.busy       = (state_q == ST_TONE);
    assign bus.tone_sel   = shift_q[0];
    assign bus.sample_out = sample;
    assign bus.bytes_sent = bytes_q;

endmodule

// File: doc/fsk_tone_generator.md
FSK_TONE_GENERATOR -- requirements
Module: fsk_tone_generator

Interface
REQ-001 Parameter FREQUENCY_1, default 9000, tone frequency in Hz for data bit 0.
REQ-002 Parameter FREQUENCY_2, default 11000, tone frequency in Hz for data bit 1; SHALL exceed FREQUENCY_1.
REQ-003 Parameter CLOCK, default 50000000, clock frequency in Hz.
REQ-004 Parameter BIT_TICKS, default 50000, duration of one data bit in clock cycles.
REQ-005 clock  input  1  single system clock, all logic on its rising edge.
REQ-006 clear  input  1  reset, asynchronous, active-low.
REQ-007 enable  input  1  high = advance all counters; low = freeze state, counters and output.
REQ-008 data_in  input  8  byte to transmit, LSB first.
REQ-009 data_valid  input  1  data_in is valid.
REQ-010 data_ready  output  1  block accepts a byte this cycle.
REQ-011 sample_out  output  1  FSK square-wave output, same signal the receiving analyzer samples.
REQ-012 busy  output  1  a byte is being transmitted.
REQ-013 tone_sel  output  1  data bit currently being sent (0 = FREQUENCY_1, 1 = FREQUENCY_2).
REQ-014 bytes_sent  output  32  count of fully transmitted bytes since reset.

Function
REQ-015 Half-period ticks SHALL be HALF1 = CLOCK/(2*FREQUENCY_1) and HALF2 = CLOCK/(2*FREQUENCY_2), integer division, computed at elaboration.
REQ-016 States SHALL be IDLE and TONE only.
REQ-017 IDLE: data_ready=1, busy=0, sample_out held at its last level, no counter advances.
REQ-018 A byte SHALL be accepted on a rising edge with data_valid=1, data_ready=1, enable=1; the byte is latched into a shift register and the state becomes TONE.
REQ-019 data_valid while enable=0 or in TONE SHALL be ignored; no input buffering.
REQ-020 TONE: data_ready=0, busy=1, tone_sel = shift register bit 0.
REQ-021 Each bit SHALL last exactly BIT_TICKS enabled cycles, counted by a bit-duration counter from 0 to BIT_TICKS-1.
REQ-022 At each bit start the half-period counter SHALL restart at 0; sample_out keeps its level (level-continuous, not phase-continuous).
REQ-023 The half-period counter SHALL count 0..HALFn-1 for the selected tone; on reaching HALFn-1, sample_out toggles and the counter returns to 0.
REQ-024 First toggle of a bit SHALL occur HALFn enabled cycles after the bit starts.
REQ-025 At the end of bit 7 the state SHALL return to IDLE and bytes_sent SHALL increment by 1 on that same edge; bytes_sent wraps from 0xFFFFFFFF to 0.
REQ-026 busy SHALL be high for exactly 8*BIT_TICKS enabled cycles per byte; minimum byte spacing is 8*BIT_TICKS+1 cycles.
REQ-027 enable low in TONE SHALL hold all counters, shift register, state and outputs unchanged.
REQ-028 All internal counters SHALL be 32 bits wide.

Reset
REQ-029 clear low SHALL asynchronously force: state IDLE, sample_out=0, busy=0, data_ready=1 once clear is released, tone_sel=0, bytes_sent=0, all counters and shift register 0.
REQ-030 clear asserted mid-byte SHALL abort that byte without incrementing bytes_sent.
REQ-031 data_ready SHALL be 0 while clear is low.

Structure
REQ-032 A shared package SHALL hold the state encoding and the half-tick computation function (CLOCK, frequency -> ticks).
REQ-033 One sub-module tone_divider (half-period counter + sample_out toggle, inputs half_ticks, restart, enable) is natural and SHALL be used.
REQ-034 Elaboration SHALL fail if FREQUENCY_2 <= FREQUENCY_1, HALF2 < 1, or BIT_TICKS < 2*HALF1.

Verification (CLOCK=1000, FREQUENCY_1=50, FREQUENCY_2=100, BIT_TICKS=40 -> HALF1=10, HALF2=5)
REQ-035 Send 0x00 -> sample_out toggles every 10 cycles, 4 toggles per bit, busy high 320 cycles, bytes_sent=1.
REQ-036 Send 0xFF -> toggles every 5 cycles, 8 per bit, tone_sel=1 throughout, bytes_sent increments once.
REQ-037 Send 0x01 -> bit 0 toggles at 5-cycle spacing, bit 1 first toggle 10 cycles after bit boundary, then 10-cycle spacing.
REQ-038 Hold data_valid high with two bytes queued -> second accepted exactly 1 cycle after busy falls; data_valid during TONE ignored.
REQ-039 Drop enable for 7 cycles mid-bit -> sample_out and counters frozen, byte duration extended by exactly 7 cycles.
REQ-040 Assert clear at cycle 100 of a byte -> outputs reset immediately, bytes_sent=0, next byte accepted normally after release.
